imem_loader: RTL and testbench

Boot-time writer for the instruction memory, which is otherwise read-only to fetch. It accepts a framed byte stream over a valid/ready handshake: a length byte, the program bytes, then an XOR checksum byte. It writes each program byte into the instruction memory's byte write port and holds the CPU in stall until a verified program is in place. It sits between the host/serial byte source and the instruction memory write port, and drives the CPU's hold input.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_xor_checksum.sv | 22 ++
 rtl/imem_loader.sv | 114 +++++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the loader FSM and its checksum helper.
package imem_loader_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int IMEM_BYTES     = 2 ** DEFAULT_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/imem_loader_xor_checksum.sv
// Running XOR of the program bytes of one load.
// Cleared when a new load starts and on reset.
module xor_checksum #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum ^ din;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives [length][program bytes][xor checksum], writes
// the bytes into instruction memory and holds the CPU until a load verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   bytes_loaded
);

    localparam int         CNT_W     = ADDR_W + 1;
    localparam logic [7:0] MAX_WORDS = 8'(2 ** (ADDR_W - 2));

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] remaining;
    logic [7:0]       checksum;
    logic             xfer;
    logic             data_xfer;
    logic             start_load;
    logic             len_bad;
    logic             csum_ok;

    assign in_ready   = (state == LEN) || (state == DATA) || (state == CHECK);
    assign xfer       = in_valid && in_ready;
    assign data_xfer  = xfer && (state == DATA);
    assign start_load = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign len_bad    = (in_data == 8'd0) || (in_data > MAX_WORDS);
    assign csum_ok    = (in_data == checksum);

    assign cpu_hold = (state != DONE);
    assign done     = (state == DONE);
    assign error    = (state == ERR);

    xor_checksum #(.W(8)) u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_load),
        .en    (data_xfer),
        .din   (in_data),
        .sum   (checksum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = LEN;
            LEN:   if (in_valid) next_state = len_bad ? ERR : DATA;
            DATA:  if (in_valid && remaining == CNT_W'(1)) next_state = CHECK;
            CHECK: if (in_valid) next_state = csum_ok ? DONE : ERR;
            DONE:  if (start) next_state = LEN;
            ERR:   if (start) next_state = LEN;
            default: next_state = IDLE;
        endcase
    end

    // bytes_loaded doubles as the write pointer; it reaches 2**ADDR_W on a
    // full load without the address ever wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err_code     <= ERR_NONE;
            bytes_loaded <= '0;
            remaining    <= '0;
        end else begin
            mem_we <= data_xfer;
            if (start_load) begin
                bytes_loaded <= '0;
                err_code     <= ERR_NONE;
            end
            if (xfer && state == LEN) begin
                if (len_bad) begin
                    err_code <= ERR_LEN;
                end else begin
                    remaining    <= CNT_W'(in_data) << 2;
                    bytes_loaded <= '0;
                end
            end
            if (data_xfer) begin
                mem_addr     <= bytes_loaded[ADDR_W-1:0];
                mem_wdata    <= in_data;
                bytes_loaded <= bytes_loaded + CNT_W'(1);
                remaining    <= remaining - CNT_W'(1);
            end
            if (xfer && state == CHECK && !csum_ok) begin
                err_code <= ERR_CSUM;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level model
// (expected memory image and final status derived from the frame contents).
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int MAXW   = 2 ** (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   bytes_loaded;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]        txData[$];
    logic [7:0]        txStream[$];
    logic [ADDR_W-1:0] wrAddr[$];
    logic [7:0]        wrData[$];
    logic [7:0]        modelMem[DEPTH];
    logic [7:0]        dutMem[DEPTH];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .bytes_loaded (bytes_loaded)
    );

    always #5 clk = ~clk;

    // Observed instruction-memory writes, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wrAddr.push_back(mem_addr);
            wrData.push_back(mem_wdata);
            dutMem[mem_addr] = mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkImage(input string tag);
        int diffs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dutMem[i] !== modelMem[i]) diffs++;
        end
        checkOutput({tag, "_image_diffs"}, diffs, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_cpu_hold"}, cpu_hold, 1);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_error"}, error, 0);
        checkOutput({tag, "_err_code"}, err_code, 0);
        checkOutput({tag, "_bytes_loaded"}, bytes_loaded, 0);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // gapMode: 0 = valid every cycle, 1 = every other cycle, 2 = random gaps.
    task automatic sendStream(input int gapMode, input int startAt, output bit timedOut);
        int  idx = 0;
        int  cycles = 0;
        bit  phase = 1'b0;
        bit  startSent = 1'b0;
        bit  idle;
        timedOut = 1'b0;
        while (idx < txStream.size()) begin
            @(negedge clk);
            start = 1'b0;
            if (!startSent && idx == startAt) begin
                start = 1'b1;
                startSent = 1'b1;
            end
            idle  = (gapMode == 1 && phase) || (gapMode == 2 && $urandom_range(0, 2) == 0);
            phase = ~phase;
            if (idle) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = txStream[idx];
                if (in_ready) idx++;
            end
            cycles++;
            if (cycles > 600) begin
                timedOut = 1'b1;
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // One framed load followed by a check of writes, status and memory image.
    task automatic applyStimulus(input string name, input int len, input int csum,
                                 input int gapMode, input int startAt);
        bit         valid, ok, to;
        int         nb;
        logic [7:0] x = 8'h00;
        wrAddr.delete();
        wrData.delete();
        pulseStart();
        valid = (len >= 1) && (len <= MAXW);
        nb    = valid ? 4 * len : 0;
        txStream.delete();
        txStream.push_back(len[7:0]);
        if (valid) begin
            for (int k = 0; k < nb; k++) begin
                txStream.push_back(txData[k]);
                x ^= txData[k];
            end
            txStream.push_back(csum[7:0]);
        end
        sendStream(gapMode, startAt, to);
        checkOutput({name, "_timeout"}, to, 0);
        ok = valid && (csum[7:0] == x);
        for (int k = 0; k < nb; k++) modelMem[k] = txData[k];
        checkOutput({name, "_write_count"}, wrAddr.size(), nb);
        for (int k = 0; k < wrAddr.size() && k < nb; k++) begin
            checkOutput($sformatf("%s_addr%0d", name, k), wrAddr[k], k);
            checkOutput($sformatf("%s_data%0d", name, k), wrData[k], txData[k]);
        end
        checkOutput({name, "_done"}, done, ok);
        checkOutput({name, "_error"}, error, !ok);
        checkOutput({name, "_cpu_hold"}, cpu_hold, !ok);
        checkOutput({name, "_err_code"}, err_code, !valid ? 1 : (ok ? 0 : 2));
        checkOutput({name, "_bytes_loaded"}, bytes_loaded, nb);
        checkOutput({name, "_in_ready"}, in_ready, 0);
        checkOutput({name, "_mem_we_idle"}, mem_we, 0);
        checkImage(name);
    endtask

    task automatic loadNominal();
        logic [7:0] nominal[24] = '{8'h20, 8'h02, 8'h00, 8'h0A, 8'h20, 8'h04, 8'h00, 8'h01,
                                    8'h11, 8'h04, 8'h00, 8'h03, 8'h21, 8'h08, 8'h00, 8'h01,
                                    8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        txData.delete();
        for (int i = 0; i < 24; i++) txData.push_back(nominal[i]);
    endtask

    initial begin
        bit         to;
        int         len, csum, gap, startAt;
        logic [7:0] x;

        for (int i = 0; i < DEPTH; i++) begin
            modelMem[i] = 8'h00;
            dutMem[i]   = 8'h00;
        end
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkResetValues("idle");

        loadNominal();
        applyStimulus("nominal", 6, 8'h3A, 0, -1);
        checkOutput("nominal_last_addr", mem_addr, 23);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart_cpu_hold", cpu_hold, 1);
        checkOutput("restart_done", done, 0);
        checkOutput("restart_in_ready", in_ready, 1);
        checkOutput("restart_bytes_loaded", bytes_loaded, 0);

        applyStimulus("bad_csum", 6, 8'h3B, 0, -1);
        applyStimulus("len_zero", 0, 0, 0, -1);
        applyStimulus("len_nine", 9, 0, 0, -1);

        txData.delete();
        x = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            txData.push_back(8'($urandom));
            x ^= txData[i];
        end
        applyStimulus("full_depth", MAXW, x, 0, -1);
        checkOutput("full_last_addr", mem_addr, DEPTH - 1);

        loadNominal();
        applyStimulus("gaps", 6, 8'h3A, 1, -1);
        applyStimulus("start_in_data", 6, 8'h3A, 0, 5);

        wrAddr.delete();
        wrData.delete();
        pulseStart();
        txStream.delete();
        txStream.push_back(8'd6);
        for (int k = 0; k < 10; k++) txStream.push_back(txData[k]);
        sendStream(0, -1, to);
        checkOutput("midreset_timeout", to, 0);
        rst_n = 1'b0;
        for (int k = 0; k < 10; k++) modelMem[k] = txData[k];
        @(negedge clk);
        checkResetValues("midreset");
        rst_n = 1'b1;
        checkOutput("midreset_write_count", wrAddr.size(), 10);
        checkImage("midreset");
        applyStimulus("after_reset", 6, 8'h3A, 0, -1);

        for (int t = 0; t < 20; t++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 255) : $urandom_range(0, MAXW);
            txData.delete();
            x = 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                txData.push_back(8'($urandom));
                if (i < 4 * len) x ^= txData[i];
            end
            csum    = ($urandom_range(0, 3) == 0) ? int'(x ^ 8'($urandom_range(1, 255))) : int'(x);
            gap     = $urandom_range(0, 2);
            startAt = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(2, 8);
            applyStimulus($sformatf("rand%0d", t), len, csum, gap, startAt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
